// File: rtl/fp_sqrt_arbiter.sv
// fp_sqrt_arbiter
//   Shares one multi-cycle fp_sqrt unit among NREQ requesters. A round-robin
//   grant picks one pending request, the block runs the unit's start/done
//   handshake and returns the result on a single response channel tagged with
//   the requester index.
//
// Parameters
//   NREQ  number of requesters (2..16)
//   ID_W  requester id width, >= clog2(NREQ)
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   per-requester request handshake (req_ready one-hot)
//   req_op                operand of requester i in bits [32*i+31:32*i]
//   resp_valid/resp_ready response handshake
//   resp_id, resp_data    requester index and square-root result
//   resp_inv              invalid-operation flag
//   busy                  high whenever the controller is not idle
//   sqrt_start, sqrt_op   start pulse and held operand to the unit
//   sqrt_done, sqrt_res   unit done level (high when idle) and result
//
// Build option
//   FP_SQRT_SPECIAL_EN    classify the operand on accept and answer zero,
//                         negative, infinity and NaN operands directly without
//                         using the unit. Undefined: every operand goes to the
//                         unit and resp_inv stays 0.

module fp_sqrt_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*32-1:0] req_op,
  output logic [NREQ-1:0]   req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [ID_W-1:0]   resp_id,
  output logic [31:0]       resp_data,
  output logic              resp_inv,
  output logic              busy,
  output logic              sqrt_start,
  output logic [31:0]       sqrt_op,
  input  logic              sqrt_done,
  input  logic [31:0]       sqrt_res
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_LO,
    WAIT_HI,
    RESP
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [ID_W-1:0] ptr;

  logic [NREQ-1:0] grant;
  logic [ID_W-1:0] grant_id;
  logic [31:0]     grant_op;
  logic            any_valid;
  logic            accept;

  logic            bypass;
  logic [31:0]     bypass_data;
  logic            bypass_inv;

  // Index reached by stepping 'step' places past 'base', wrapping modulo NREQ.
  // step is at most NREQ and base below NREQ, so one subtraction suffices.
  function automatic int unsigned wrap_idx(input logic [ID_W-1:0] base,
                                           input int unsigned step);
    int unsigned s;
    s = 32'(base) + step;
    return (s >= NREQ) ? s - NREQ : s;
  endfunction

  // Round-robin search starting just after ptr. The inner loop compares
  // against constant indices so no variable bit-select is needed.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    any_valid = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!any_valid && req_valid[i] && (wrap_idx(ptr, k) == i)) begin
          grant[i]  = 1'b1;
          grant_id  = ID_W'(i);
          any_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_op = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        grant_op = req_op[32*i +: 32];
      end
    end
  end

  // Grants are masked while reset is held so nothing looks accepted during it.
  assign req_ready = (state == IDLE && rst_n) ? grant : '0;
  assign accept    = (state == IDLE) && any_valid && rst_n;
  assign busy      = (state != IDLE);

`ifdef FP_SQRT_SPECIAL_EN
  // Operand classification. NaN is checked before the sign so a negative NaN
  // is passed through as quiet NaN without raising invalid.
  always_comb begin
    bypass      = 1'b0;
    bypass_data = '0;
    bypass_inv  = 1'b0;
    if (grant_op[30:23] == 8'h00) begin
      bypass      = 1'b1;
      bypass_data = {grant_op[31], 31'd0};
    end else if (grant_op[30:23] == 8'hFF && grant_op[22:0] != 23'd0) begin
      bypass      = 1'b1;
      bypass_data = 32'h7FC0_0000;
    end else if (grant_op[31]) begin
      bypass      = 1'b1;
      bypass_data = 32'h7FC0_0000;
      bypass_inv  = 1'b1;
    end else if (grant_op[30:23] == 8'hFF) begin
      bypass      = 1'b1;
      bypass_data = 32'h7F80_0000;
    end
  end
`else
  assign bypass      = 1'b0;
  assign bypass_data = '0;
  assign bypass_inv  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // WAIT_LO exists so the idle-high sqrt_done left over from before the start
  // pulse is not mistaken for completion.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = bypass ? RESP : START;
        end
      end
      START:   state_next = WAIT_LO;
      WAIT_LO: if (!sqrt_done) state_next = WAIT_HI;
      WAIT_HI: if (sqrt_done) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr        <= ID_W'(NREQ - 1);
      sqrt_start <= 1'b0;
      sqrt_op    <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
      resp_inv   <= 1'b0;
    end else begin
      sqrt_start <= accept && !bypass;
      if (accept) begin
        resp_id  <= grant_id;
        resp_inv <= bypass_inv;
        if (bypass) begin
          resp_data  <= bypass_data;
          resp_valid <= 1'b1;
        end else begin
          sqrt_op <= grant_op;
        end
      end
      if (state == WAIT_HI && sqrt_done) begin
        resp_data  <= sqrt_res;
        resp_valid <= 1'b1;
      end
      // The pointer moves only when a response is consumed, so the winner of
      // this round has lowest priority in the next.
      if (state == RESP && resp_ready) begin
        resp_valid <= 1'b0;
        ptr        <= resp_id;
      end
    end
  end

endmodule

// File: tb/tb_fp_sqrt_arbiter.sv
module tb_fp_sqrt_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned ID_W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*32-1:0]  req_op;
  logic [NREQ-1:0]     req_ready;
  logic                resp_valid;
  logic                resp_ready;
  logic [ID_W-1:0]     resp_id;
  logic [31:0]         resp_data;
  logic                resp_inv;
  logic                busy;
  logic                sqrt_start;
  logic [31:0]         sqrt_op;
  logic                sqrt_done = 1'b1;
  logic [31:0]         sqrt_res  = '0;

  fp_sqrt_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_inv   (resp_inv),
    .busy       (busy),
    .sqrt_start (sqrt_start),
    .sqrt_op    (sqrt_op),
    .sqrt_done  (sqrt_done),
    .sqrt_res   (sqrt_res)
  );

  // Unit model: done drops the cycle after start, rises 30 cycles later.
  function automatic logic [31:0] model_sqrt(input logic [31:0] x);
    case (x)
      32'h4080_0000: return 32'h4000_0000;
      32'h4110_0000: return 32'h4040_0000;
      32'h3F80_0000: return 32'h3F80_0000;
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  int unsigned unit_cnt = 0;
  always @(posedge clk) begin
    if (sqrt_start) begin
      sqrt_done <= 1'b0;
      unit_cnt  <= 30;
    end else if (unit_cnt != 0) begin
      unit_cnt <= unit_cnt - 1;
      if (unit_cnt == 1) begin
        sqrt_done <= 1'b1;
        sqrt_res  <= model_sqrt(sqrt_op);
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     data;
    logic            inv;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_accept(output bit got, output int gid, output int acc_cyc);
    got = 1'b0;
    gid = 0;
    acc_cyc = 0;
    for (int k = 0; k < 64; k++) begin
      #1;
      if ((req_valid & req_ready) != '0) begin
        got = 1'b1;
        acc_cyc = cyc;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) gid = i;
        break;
      end
      @(negedge clk);
    end
    check("accept_timeout", 32'(got), 32'd1);
  endtask

  task automatic run_op(input logic [NREQ-1:0] mask, input bit keep, input int stall,
                        input int exp_lat, input int exp_starts);
    exp_t e;
    bit got, seen, bad_ready, unstable;
    int gid, a, starts, lat;
    logic [ID_W-1:0] hid;
    logic [31:0] hdata;
    resp_ready = (stall == 0);
    req_valid  = mask;
    wait_accept(got, gid, a);
    if (!got) return;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    check("grant_id", 32'(gid), 32'(e.id));
    starts = 0;
    bad_ready = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!keep) req_valid = '0;
      #1;
      if (sqrt_start) starts++;
      if (req_ready != '0) bad_ready = 1'b1;
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("resp_timeout", 32'(seen), 32'd1);
    lat = cyc - a;
    check("latency", 32'(lat), 32'(exp_lat));
    check("start_pulses", 32'(starts), 32'(exp_starts));
    check("ready_while_busy", 32'(bad_ready), 32'd0);
    check("resp_id", 32'(resp_id), 32'(e.id));
    check("resp_data", resp_data, e.data);
    check("resp_inv", 32'(resp_inv), 32'(e.inv));
    if (stall > 0) begin
      hid = resp_id;
      hdata = resp_data;
      unstable = 1'b0;
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        #1;
        if (!resp_valid || resp_id !== hid || resp_data !== hdata || req_ready != '0)
          unstable = 1'b1;
      end
      check("stall_stable", 32'(unstable), 32'd0);
      resp_ready = 1'b1;
    end
    @(negedge clk);
    #1;
    check("resp_cleared", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got, seen;
    int gid, a;

    // Reset with all requesters pending
    rst_n = 1'b0;
    req_valid = '1;
    req_op = '0;
    resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sqrt_start", 32'(sqrt_start), 32'd0);
    check("rst_sqrt_op", sqrt_op, 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_inv", 32'(resp_inv), 32'd0);
    rst_n = 1'b1;
    #1;
    check("first_grant", 32'(req_ready), 32'h1);
    req_valid = '0;
    @(negedge clk);

    // All requesters held valid: rotation 0,1,2,3,0,1,2,3
    for (int i = 0; i < NREQ; i++) req_op[32*i +: 32] = 32'h4110_0000;
    for (int n = 0; n < 8; n++) sb.push_back('{ID_W'(n % NREQ), 32'h4040_0000, 1'b0});
    for (int n = 0; n < 8; n++) run_op('1, 1'b1, 0, 33, 1);
    req_valid = '0;

    // Single request from requester 2, sqrt(4.0)
    @(negedge clk);
    req_op[64 +: 32] = 32'h4080_0000;
    sb.push_back('{ID_W'(2), 32'h4000_0000, 1'b0});
    run_op(4'b0100, 1'b0, 0, 33, 1);

    // Response stall of 10 cycles
    @(negedge clk);
    req_op[96 +: 32] = 32'h4110_0000;
    sb.push_back('{ID_W'(3), 32'h4040_0000, 1'b0});
    run_op(4'b1000, 1'b0, 10, 33, 1);

    // Reset while waiting for the unit aborts the operation
    @(negedge clk);
    req_op[32 +: 32] = 32'h4080_0000;
    req_valid = 4'b0010;
    wait_accept(got, gid, a);
    @(negedge clk);
    req_valid = '0;
    repeat (10) @(negedge clk);
    #1;
    check("busy_before_abort", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (resp_valid) seen = 1'b1;
    end
    check("no_resp_after_abort", 32'(seen), 32'd0);
    req_op[0 +: 32] = 32'h3F80_0000;
    sb.push_back('{ID_W'(0), 32'h3F80_0000, 1'b0});
    run_op(4'b0001, 1'b0, 0, 33, 1);

`ifdef FP_SQRT_SPECIAL_EN
    // Special operands bypass the unit; response one cycle after accept
    @(negedge clk);
    req_op[0 +: 32] = 32'hC080_0000;
    sb.push_back('{ID_W'(0), 32'h7FC0_0000, 1'b1});
    run_op(4'b0001, 1'b0, 0, 1, 0);
    @(negedge clk);
    req_op[32 +: 32] = 32'h7F80_0000;
    sb.push_back('{ID_W'(1), 32'h7F80_0000, 1'b0});
    run_op(4'b0010, 1'b0, 0, 1, 0);
    @(negedge clk);
    req_op[64 +: 32] = 32'h8000_0000;
    sb.push_back('{ID_W'(2), 32'h8000_0000, 1'b0});
    run_op(4'b0100, 1'b0, 0, 1, 0);
    @(negedge clk);
    req_op[96 +: 32] = 32'h4080_0000;
    sb.push_back('{ID_W'(3), 32'h4000_0000, 1'b0});
    run_op(4'b1000, 1'b0, 0, 33, 1);
`endif

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
